// File: rtl/master_out_port_pkg.sv
// Shared bus definitions for the master output port and the matching slave input port.
// Holds the field widths, the state encoding and the burst-length helper.
package master_out_port_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 12;
  localparam int CNT_W   = 4;

  // Bit counter values on the final serial bit of an address beat / data-only beat
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_REQ  = 3'd1,
    ADDR_TX   = 3'd2,
    BURST_REQ = 3'd3,
    BURST_TX  = 3'd4
  } bus_state_e;

  // A requested burst of zero beats still moves one beat.
  function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] b);
    return (b == '0) ? BURST_W'(1) : b;
  endfunction

endpackage

// File: rtl/master_out_port_piso.sv
// Parallel-load, LSB-first shift register; zeros shift in from the top.
// Load has priority over shift.
module bus_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {1'b0, sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[0];

endmodule

// File: rtl/master_out_port.sv
// Serial bus master: sends a 12-bit address + 8-bit data first beat, then
// data-only beats for the rest of the burst, LSB first on two serial lines.
module master_out_port
  import master_out_port_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  data,
  input  logic               read_en,
  input  logic               write_en,
  input  logic [BURST_W-1:0] burst,
  input  logic               slave_ready,
  output logic               master_valid,
  output logic               tx_address,
  output logic               tx_data,
  output logic               read_en_out,
  output logic               write_en_out,
  output logic               busy,
  output logic               data_req,
  output logic               tx_done,
  output logic [BURST_W-1:0] beat_count,
  output bus_state_e         state_dbg
);

  // Handshake: a beat is accepted on the rising clk edge where master_valid and
  // slave_ready are both high; master_valid never drops before that edge and
  // bit 0 of the beat stays on the lines while it waits.
  bus_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BURST_W-1:0] beat_count_q, beat_count_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic               data_req_q, data_req_d;
  logic               tx_done_q, tx_done_d;

  logic               handshake, end_beat;
  logic               addr_load, addr_shift, data_load, data_shift;
  logic [DATA_W-1:0]  data_din;
  logic               addr_bit, data_bit;
  logic [BURST_W-1:0] beat_inc;

  assign handshake = master_valid & slave_ready;
  assign beat_inc  = beat_count_q + BURST_W'(1);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    beat_count_d = beat_count_q;
    burst_d      = burst_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    data_req_d   = 1'b0;
    tx_done_d    = 1'b0;
    end_beat     = 1'b0;
    addr_load    = 1'b0;
    addr_shift   = 1'b0;
    data_load    = 1'b0;
    data_shift   = 1'b0;
    data_din     = wr_q ? data : '0;

    case (state_q)
      IDLE: begin
        if (start && (read_en ^ write_en)) begin
          state_d      = ADDR_REQ;
          rd_d         = read_en;
          wr_d         = write_en;
          burst_d      = eff_burst(burst);
          beat_count_d = '0;
          bit_cnt_d    = '0;
          addr_load    = 1'b1;
          data_load    = 1'b1;
          data_din     = write_en ? data : '0;
        end
      end
      ADDR_REQ: begin
        if (handshake) begin
          state_d    = ADDR_TX;
          addr_shift = 1'b1;
          data_shift = 1'b1;
          bit_cnt_d  = '0;
        end
      end
      ADDR_TX: begin
        addr_shift = 1'b1;
        data_shift = 1'b1;
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end_beat   = (bit_cnt_q == ADDR_LAST);
      end
      BURST_REQ: begin
        // First cycle is the data_req gap: next-beat data is loaded, valid stays low.
        if (data_req_q) begin
          data_load = 1'b1;
        end else if (handshake) begin
          state_d    = BURST_TX;
          data_shift = 1'b1;
          bit_cnt_d  = '0;
        end
      end
      BURST_TX: begin
        data_shift = 1'b1;
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end_beat   = (bit_cnt_q == DATA_LAST);
      end
      default: state_d = IDLE;
    endcase

    if (end_beat) begin
      beat_count_d = beat_inc;
      if (beat_inc == burst_q) begin
        state_d   = IDLE;
        tx_done_d = 1'b1;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
      end else begin
        state_d    = BURST_REQ;
        data_req_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      beat_count_q <= '0;
      burst_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      data_req_q   <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      beat_count_q <= beat_count_d;
      burst_q      <= burst_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      data_req_q   <= data_req_d;
      tx_done_q    <= tx_done_d;
    end
  end

  bus_piso #(.W(ADDR_W)) u_addr_piso (
    .clk   (clk),
    .reset (reset),
    .load  (addr_load),
    .shift (addr_shift),
    .din   (address),
    .dout  (addr_bit)
  );

  bus_piso #(.W(DATA_W)) u_data_piso (
    .clk   (clk),
    .reset (reset),
    .load  (data_load),
    .shift (data_shift),
    .din   (data_din),
    .dout  (data_bit)
  );

  // All outputs are decoded from flops only, so reset clears them immediately.
  assign busy         = (state_q != IDLE);
  assign master_valid = (state_q == ADDR_REQ) || ((state_q == BURST_REQ) && !data_req_q);
  assign tx_address   = addr_bit & ((state_q == ADDR_REQ) || (state_q == ADDR_TX));
  assign tx_data      = data_bit & busy & ~data_req_q;
  assign read_en_out  = rd_q;
  assign write_en_out = wr_q;
  assign data_req     = data_req_q;
  assign tx_done      = tx_done_q;
  assign beat_count   = beat_count_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/master_out_port.md
MASTER_OUT_PORT -- requirements
Module: master_out_port

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a transaction, sampled only in IDLE.
REQ-004 SHALL have port: address  input  12  start address, captured on accepted start.
REQ-005 SHALL have port: data  input  8  write data, captured at start (beat 0) and at each data_req cycle (later beats).
REQ-006 SHALL have port: read_en / write_en  input  1 each  transaction type, captured on start; both high or both low means start is ignored.
REQ-007 SHALL have port: burst  input  12  beat count, captured on start; 0 is treated as 1.
REQ-008 SHALL have port: slave_ready  input  1  downstream ready.
REQ-009 SHALL have port: master_valid  output  1  beat request to the slave.
REQ-010 SHALL have port: tx_address / tx_data  output  1 each  serial address and data lines, LSB first.
REQ-011 SHALL have port: read_en_out / write_en_out  output  1 each  registered transaction type, held for the whole transaction.
REQ-012 SHALL have port: busy  output  1  high from accepted start until return to IDLE.
REQ-013 SHALL have port: data_req  output  1  one-cycle pulse requesting next-beat data.
REQ-014 SHALL have port: tx_done  output  1  one-cycle pulse when the last beat completes.
REQ-015 SHALL have port: beat_count  output  12  number of beats completed.

Function
REQ-016 SHALL define handshake as master_valid & slave_ready at a rising clk edge.
REQ-017 SHALL implement the states IDLE, ADDR_REQ, ADDR_TX, BURST_REQ, BURST_TX.
REQ-018 IDLE: on a valid start SHALL load the shift registers, set busy and assert master_valid on the next cycle (ADDR_REQ), with address[0] on tx_address and, for a write, data[0] on tx_data.
REQ-019 ADDR_REQ SHALL hold master_valid and bit 0 until handshake; master_valid SHALL drop the cycle after handshake.
REQ-020 ADDR_TX SHALL drive address bits 1..11 on 11 consecutive cycles after the handshake, and write data bits 1..7 on the first 7 of those cycles; tx_data SHALL be 0 otherwise and for reads.
REQ-021 At the end of ADDR_TX, beat_count SHALL increment; the block SHALL then go to IDLE with tx_done if beat_count reaches the effective burst, else to BURST_REQ with data_req pulsed for one cycle.
REQ-022 BURST_REQ SHALL capture data in the data_req cycle, assert master_valid from the following cycle with data bit 0 (writes) and tx_address=0, and wait for handshake.
REQ-023 BURST_TX SHALL drive data bits 1..7 on 7 cycles after the handshake; the address is never resent, since the slave increments it internally.
REQ-024 At the end of BURST_TX, beat_count SHALL increment, then REQ-021 completion and continuation rules apply.
REQ-025 Read bursts SHALL use identical beat timing with tx_data held 0.
REQ-026 Minimum gap SHALL be 1 cycle with master_valid low between the last bit of one beat and master_valid of the next.
REQ-027 start while busy SHALL be ignored; captured inputs SHALL NOT change mid-transaction.
REQ-028 slave_ready low indefinitely SHALL leave the block in its REQ state, with no timeout.
REQ-029 beat_count SHALL clear on accepted start and SHALL NOT wrap; burst=4095 yields a maximum of 4095.

Reset
REQ-030 Reset SHALL force state IDLE and drive every output to 0 (master_valid, tx_address, tx_data, read_en_out, write_en_out, busy, data_req, tx_done, beat_count), and clear the shift registers.
REQ-031 Reset asserted mid-beat SHALL abort immediately, with no partial bits driven after reset release.

Structure
REQ-032 A shared package SHALL hold ADDR_W=12, DATA_W=8, BURST_W=12 and the state encoding, shared with the slave input port.
REQ-033 SHALL instantiate one sub-module, bus_piso: a parameterised-width parallel-load LSB-first shift register with load and shift enables, used for both address and data.

Verification
REQ-034 Single write: address=0x5A3, data=0xC6, burst=1, slave_ready=1 -> handshake on the first valid cycle; tx_address carries 1,1,0,0,0,1,0,1,1,0,1,0 over 12 cycles; tx_data carries 0,1,1,0,0,0,1,1; tx_done one cycle after the last bit; beat_count=1.
REQ-035 Backpressure: slave_ready held low for 5 cycles after master_valid -> master_valid and bit 0 stable for all 5 cycles; shifting begins only after the handshake.
REQ-036 Write burst=3 with data 0x11, 0x22, 0x33 supplied on the data_req pulses -> beats of 12, 8 and 8 cycles; exactly two data_req pulses; tx_address=0 during beats 1-2; beat_count=3.
REQ-037 Read with burst=0 -> behaves as burst=1; tx_data stays 0; read_en_out=1 throughout; write_en_out=0.
REQ-038 start pulsed with read_en=write_en=1, and start pulsed while busy -> both ignored; outputs unchanged.
REQ-039 Reset asserted at address bit 6 of beat 0 -> all outputs 0 on the reset edge; a new start after release behaves as REQ-034.
